clk_step_ctrl: RTL and testbench
================================

Name: clk_step_ctrl

Overview:
- Run-control front end for the CPU timebase. Generates a one-cycle clock-enable pulse (`cpu_ce`) that paces the core.
- Three modes:
  - HALT: no pulses.
  - RUN: one pulse every programmable N cycles.
  - STEP: one pulse per debounced push-button press.
- Sits between the board clock/buttons and the core; the divisor is writable from the debug/config bus. The core stays on `clk` and uses `cpu_ce` only; no derived clocks.

Parameters:
- CNT_W, 32, width of divisor, counter and pulse counter
- DEFAULT_DIV, 250000, reset value of the divisor (cycles per pulse in RUN)
- DEB_CYCLES, 100000, cycles `step_btn` must be stable before a level change is accepted
- DEB_W, 17, width of the debounce counter; must satisfy 2^DEB_W > DEB_CYCLES

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- mode  in  2  00=HALT, 01=RUN, 10=STEP, 11=HALT
- step_btn  in  1  raw asynchronous push-button, active-high
- div_we  in  1  divisor write strobe
- div_wdata  in  CNT_W  new divisor
- cpu_ce  out  1  one-cycle enable pulse to core
- div_cur  out  CNT_W  current divisor register
- state_o  out  2  FSM state (00 HALT, 01 RUN, 10 STEP)
- pulse_cnt  out  CNT_W  number of `cpu_ce` pulses issued since reset

Behaviour:
- Reset (`rst`=1 at posedge):
  - state=HALT, `cpu_ce`=0, `pulse_cnt`=0, `div_cur`=DEFAULT_DIV.
  - Internal counter=0, sync flops=0, debounced level=0, debounce counter=0.
  - Reset mid-pulse kills the pulse in the following cycle.
- All outputs are registered.
- Divisor register:
  - `div_we`=1 loads `div_wdata`; a value of 0 is stored as 1.
  - The write also clears the RUN counter in the same cycle. The new period starts from 0, with no pulse that cycle.
- FSM:
  - State follows `mode` every cycle: the registered state equals `mode` decoded, with 1 cycle latency.
  - Any state change clears the RUN counter and suppresses `cpu_ce` for that cycle.
- RUN:
  - Counter increments each cycle.
  - When counter == div_cur-1: `cpu_ce`=1 for exactly one cycle and counter wraps to 0.
  - Period is exactly div_cur cycles. div_cur=1 gives `cpu_ce` continuously high.
  - First pulse is div_cur cycles after entering RUN.
- STEP:
  - `step_btn` passes a 2-flop synchronizer, which runs in all states.
  - Debouncer: if the synchronized value != debounced level, the debounce counter increments; otherwise it clears. When the counter reaches DEB_CYCLES-1, the debounced level flips and the counter clears.
  - A rising edge of the debounced level while state==STEP gives `cpu_ce`=1 on the next cycle, for exactly one cycle.
  - Latency: a clean press held stable gives `cpu_ce` exactly DEB_CYCLES+3 cycles after `step_btn` rises.
  - Holding the button yields one pulse only. A glitch shorter than DEB_CYCLES yields none.
  - A debounced edge occurring in HALT/RUN is discarded; it does not pulse on a later STEP entry.
- HALT: `cpu_ce`=0; counter held at 0.
- `pulse_cnt` increments on every `cpu_ce`=1 cycle and wraps modulo 2^CNT_W.
- Simultaneous events:
  - `div_we` during a would-be RUN tick: the write wins and no pulse is issued.
  - A mode change and a step edge in the same cycle: no pulse.

Decomposition:
- Shared constants (add to `define.v`): mode encodings MODE_HALT/MODE_RUN/MODE_STEP; the default divisor reuses the existing 25_0000 constant.
- Sub-module `btn_debounce` (synchronizer + debouncer; output = debounced level + one-cycle rise pulse). It is reusable for other board buttons.
- Top holds the FSM, divisor register, RUN counter and `pulse_cnt`.

Test Plan (DEFAULT_DIV=4, DEB_CYCLES=4):
- Reset then mode=01 → `cpu_ce` high on cycles 4, 8, 12 after state enters RUN; `pulse_cnt`=3 after cycle 12; `div_cur`=4.
- In RUN, write `div_wdata`=2 mid-period → no pulse in the write cycle, then pulses every 2 cycles; write 0 → `div_cur`=1, `cpu_ce` continuously high.
- mode=10, `step_btn` held high 20 cycles → exactly one `cpu_ce`, 7 cycles after the rise; release and press again → second pulse; `pulse_cnt`=2.
- mode=10, `step_btn` glitches high for 3 cycles → no `cpu_ce`; debounced level stays 0.
- RUN then mode=00 one cycle before a tick → no pulse; `cpu_ce` stays 0 in HALT; return to RUN → first pulse 4 cycles later.
- Assert `rst` while in RUN on the `cpu_ce` cycle → next cycle `cpu_ce`=0, state=00, `pulse_cnt`=0, `div_cur`=4.

Source files
------------

// File: rtl/clk_step_ctrl_pkg.sv
// Shared constants for the CPU run-control front end: mode encodings,
// FSM state codes and the mode-to-state decode.
package clk_step_ctrl_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_HALT = 2'b00;
    localparam mode_t MODE_RUN  = 2'b01;
    localparam mode_t MODE_STEP = 2'b10;

    localparam logic [1:0] ST_HALT = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_STEP = 2'b10;

    localparam int unsigned DIV_25_0000 = 25_0000;

    // The unused encoding 2'b11 parks the core like HALT.
    function automatic logic [1:0] mode_to_state(input mode_t mode);
        case (mode)
            MODE_RUN:  return ST_RUN;
            MODE_STEP: return ST_STEP;
            default:   return ST_HALT;
        endcase
    endfunction

endpackage

// File: rtl/clk_step_ctrl_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer followed by a stability
// debouncer. Reports the debounced level and a one-cycle rising-edge pulse.
module clk_step_ctrl_btn_debounce #(
    parameter int unsigned DEB_CYCLES = 100000,
    parameter int          DEB_W      = 17
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise
);

    logic [1:0]       r_sync;
    logic [DEB_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;

    logic w_differs;
    logic w_settled;

    assign w_differs = (r_sync[1] != r_level);
    assign w_settled = (r_cnt == DEB_W'(DEB_CYCLES - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, which is what makes the synchronizer a chain.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_btn};
            r_rise <= 1'b0;
            if (w_differs) begin
                if (w_settled) begin
                    r_level <= r_sync[1];
                    r_rise  <= r_sync[1];
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + DEB_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;

endmodule

// File: rtl/clk_step_ctrl.sv
// CPU timebase run control: emits the cpu_ce enable in HALT, RUN (every
// div_cur cycles) or STEP (one per debounced button press) mode.
module clk_step_ctrl
    import clk_step_ctrl_pkg::*;
#(
    parameter int          CNT_W       = 32,
    parameter int unsigned DEFAULT_DIV = DIV_25_0000,
    parameter int unsigned DEB_CYCLES  = 100000,
    parameter int          DEB_W       = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             step_btn,
    input  logic             div_we,
    input  logic [CNT_W-1:0] div_wdata,
    output logic             cpu_ce,
    output logic [CNT_W-1:0] div_cur,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] pulse_cnt
);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_pulse_cnt;
    logic             r_ce;

    logic [1:0] w_next_state;
    logic       w_state_chg;
    logic       w_run_tick;
    logic       w_deb_level;
    logic       w_deb_rise;
    logic       w_ce_next;

    clk_step_ctrl_btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .DEB_W      (DEB_W)
    ) u_deb (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_btn   (step_btn),
        .o_level (w_deb_level),
        .o_rise  (w_deb_rise)
    );

    assign w_next_state = mode_to_state(mode);
    assign w_state_chg  = (w_next_state != r_state);
    assign w_run_tick   = (r_state == ST_RUN) && (r_cnt == r_div - CNT_W'(1));

    // A state change swallows both a RUN tick and a STEP edge; a divisor
    // write only competes with the RUN tick.
    // NOTE: default assignment first so no path through the block infers a latch.
    always_comb begin
        w_ce_next = 1'b0;
        if (!w_state_chg) begin
            case (r_state)
                ST_RUN:  w_ce_next = w_run_tick && !div_we;
                ST_STEP: w_ce_next = w_deb_rise && w_deb_level;
                default: w_ce_next = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_HALT;
            r_div       <= CNT_W'(DEFAULT_DIV);
            r_cnt       <= '0;
            r_pulse_cnt <= '0;
            r_ce        <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_ce    <= w_ce_next;

            if (div_we) begin
                r_div <= (div_wdata == '0) ? CNT_W'(1) : div_wdata;
            end

            if (w_state_chg || div_we || (r_state != ST_RUN) || w_run_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            // Counted alongside the pulse so pulse_cnt already includes it.
            if (w_ce_next) begin
                r_pulse_cnt <= r_pulse_cnt + CNT_W'(1);
            end
        end
    end

    assign cpu_ce    = r_ce;
    assign div_cur   = r_div;
    assign state_o   = r_state;
    assign pulse_cnt = r_pulse_cnt;

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Directed bench for clk_step_ctrl with DEFAULT_DIV=4, DEB_CYCLES=4.
module tb_clk_step_ctrl;

    localparam int CNT_W = 32;

    logic             clk;
    logic             rst;
    logic [1:0]       mode;
    logic             step_btn;
    logic             div_we;
    logic [CNT_W-1:0] div_wdata;
    logic             cpu_ce;
    logic [CNT_W-1:0] div_cur;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] pulse_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    clk_step_ctrl #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (4),
        .DEB_CYCLES  (4),
        .DEB_W       (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .step_btn  (step_btn),
        .div_we    (div_we),
        .div_wdata (div_wdata),
        .cpu_ce    (cpu_ce),
        .div_cur   (div_cur),
        .state_o   (state_o),
        .pulse_cnt (pulse_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs n cycles; cpu_ce is expected at cycle `first` and then every
    // `period` cycles (period 0: only once; first 0: never).
    task automatic expect_ce(input string tag, input int n, input int first, input int period);
        for (int k = 1; k <= n; k++) begin
            logic e;
            tick();
            e = (first != 0) && ((k == first) ||
                (period != 0 && k > first && ((k - first) % period) == 0));
            check($sformatf("%s_c%0d", tag, k), 32'(cpu_ce), 32'(e));
        end
    endtask

    initial begin
        rst = 1'b1; mode = 2'b00; step_btn = 1'b0; div_we = 1'b0; div_wdata = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_ce", 32'(cpu_ce), 0);
        check("rst_state", 32'(state_o), 0);
        check("rst_pcnt", pulse_cnt, 0);
        check("rst_div", div_cur, 4);

        // RUN at the default divisor
        mode = 2'b01;
        tick();
        check("run_enter_state", 32'(state_o), 1);
        check("run_enter_ce", 32'(cpu_ce), 0);
        expect_ce("run4", 12, 4, 4);
        check("run4_pcnt", pulse_cnt, 3);
        check("run4_div", div_cur, 4);

        // Mid-period write of 2
        tick();
        check("pre_wr_ce", 32'(cpu_ce), 0);
        div_we = 1'b1; div_wdata = 2;
        tick();
        div_we = 1'b0;
        check("wr2_ce", 32'(cpu_ce), 0);
        check("wr2_div", div_cur, 2);
        expect_ce("run2", 6, 2, 2);
        check("run2_pcnt", pulse_cnt, 6);

        // Write of 0 lands on a would-be tick: write wins, stored as 1
        tick();
        check("run2_c7", 32'(cpu_ce), 0);
        div_we = 1'b1; div_wdata = 0;
        tick();
        div_we = 1'b0;
        check("wr0_ce", 32'(cpu_ce), 0);
        check("wr0_div", div_cur, 1);
        expect_ce("run1", 5, 1, 1);
        check("run1_pcnt", pulse_cnt, 11);

        // Back to 4, then leave RUN one cycle before the tick
        div_we = 1'b1; div_wdata = 4;
        tick();
        div_we = 1'b0;
        check("wr4_ce", 32'(cpu_ce), 0);
        expect_ce("pre_halt", 3, 0, 0);
        mode = 2'b00;
        tick();
        check("halt_ce", 32'(cpu_ce), 0);
        check("halt_state", 32'(state_o), 0);
        expect_ce("halt", 5, 0, 0);
        mode = 2'b01;
        tick();
        expect_ce("rerun", 4, 4, 0);
        check("rerun_pcnt", pulse_cnt, 12);

        // STEP: held press, release, second press
        mode = 2'b10;
        tick();
        check("step_state", 32'(state_o), 2);
        check("step_enter_ce", 32'(cpu_ce), 0);
        step_btn = 1'b1;
        expect_ce("press1", 20, 7, 0);
        check("press1_pcnt", pulse_cnt, 13);
        step_btn = 1'b0;
        expect_ce("rel1", 10, 0, 0);
        step_btn = 1'b1;
        expect_ce("press2", 20, 7, 0);
        check("press2_pcnt", pulse_cnt, 14);
        step_btn = 1'b0;
        expect_ce("rel2", 10, 0, 0);

        // 3-cycle glitch; the clean press after it proves the level stayed low
        step_btn = 1'b1;
        expect_ce("glitch_hi", 3, 0, 0);
        step_btn = 1'b0;
        expect_ce("glitch_lo", 10, 0, 0);
        check("glitch_pcnt", pulse_cnt, 14);
        step_btn = 1'b1;
        expect_ce("press3", 20, 7, 0);
        check("press3_pcnt", pulse_cnt, 15);
        step_btn = 1'b0;
        expect_ce("rel3", 10, 0, 0);

        // Edge debounced in HALT must not fire on STEP entry
        mode = 2'b00;
        tick();
        step_btn = 1'b1;
        expect_ce("halt_press", 10, 0, 0);
        mode = 2'b10;
        tick();
        check("late_step_ce", 32'(cpu_ce), 0);
        expect_ce("late_step", 8, 0, 0);
        step_btn = 1'b0;
        expect_ce("rel4", 10, 0, 0);
        check("discard_pcnt", pulse_cnt, 15);

        // Reset lands on a pulse cycle
        mode = 2'b01; div_we = 1'b1; div_wdata = 3;
        tick();
        div_we = 1'b0;
        check("fin_div", div_cur, 3);
        expect_ce("run3", 3, 3, 0);
        check("run3_pcnt", pulse_cnt, 16);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_ce", 32'(cpu_ce), 0);
        check("rst2_state", 32'(state_o), 0);
        check("rst2_pcnt", pulse_cnt, 0);
        check("rst2_div", div_cur, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
